nurn_update_engine: RTL and testbench

NURN_UPDATE_ENGINE -- requirements
Module: nurn_update_engine

---
 rtl/nurn_update_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_nurn_update_engine.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nurn_update_engine.sv
`default_nettype none
// ============================================================================
//  Module   : nurn_update_engine
//  Purpose  : Per-neuron membrane update. A job (neuron state + parameters) is
//             latched on start_i. A stream of synapse beats is accumulated
//             with signed saturation. An optional LIF leak is applied, the
//             threshold is compared, and the updated neuron state is
//             presented on a valid/ready result port.
//  Ports    : clk_i, rst_i (async, active-high)
//             start_i + job inputs (nurnId_i, membPot_i, th_i, rstPot_i,
//               refracCnt_i, refracPeriod_i, nurnType_i, leakShift_i)
//             synapse stream  : syn_valid_i / syn_ready_o, syn_weight_i,
//                               syn_spike_i, syn_last_i
//             result stream   : result_valid_o / result_ready_i,
//                               result_nurnId_o, result_membPot_o,
//                               result_refracCnt_o, outSpike_o
//             busy_o          : high whenever a job is in flight
//  Config   : NURN_LEAK_EN - when defined, type 2 (LIF) applies the leak
//             acc -= acc >>> leakShift in an extra LEAK cycle. When undefined,
//             the LEAK state is bypassed and type 2 behaves as I&F.
//  Revision : 1.0 - initial release
// ============================================================================
module nurn_update_engine #(
    parameter int DATA_BIT_WIDTH_INT   = 8,
    parameter int DATA_BIT_WIDTH_FRAC  = 8,
    parameter int NURN_CNT_BIT_WIDTH   = 8,
    parameter int REFRAC_BIT_WIDTH     = 4,
    parameter int LEAK_SHIFT_BIT_WIDTH = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              start_i,
    input  logic [NURN_CNT_BIT_WIDTH-1:0]                     nurnId_i,
    input  logic [DATA_BIT_WIDTH_INT+DATA_BIT_WIDTH_FRAC-1:0] membPot_i,
    input  logic [DATA_BIT_WIDTH_INT+DATA_BIT_WIDTH_FRAC-1:0] th_i,
    input  logic [DATA_BIT_WIDTH_INT+DATA_BIT_WIDTH_FRAC-1:0] rstPot_i,
    input  logic [REFRAC_BIT_WIDTH-1:0]                       refracCnt_i,
    input  logic [REFRAC_BIT_WIDTH-1:0]                       refracPeriod_i,
    input  logic [1:0]                                        nurnType_i,
    input  logic [LEAK_SHIFT_BIT_WIDTH-1:0]                   leakShift_i,
    input  logic                                              syn_valid_i,
    output logic                                              syn_ready_o,
    input  logic [DATA_BIT_WIDTH_INT+DATA_BIT_WIDTH_FRAC-1:0] syn_weight_i,
    input  logic                                              syn_spike_i,
    input  logic                                              syn_last_i,
    output logic                                              result_valid_o,
    input  logic                                              result_ready_i,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                     result_nurnId_o,
    output logic [DATA_BIT_WIDTH_INT+DATA_BIT_WIDTH_FRAC-1:0] result_membPot_o,
    output logic [REFRAC_BIT_WIDTH-1:0]                       result_refracCnt_o,
    output logic                                              outSpike_o,
    output logic                                              busy_o
);

    localparam int DSIZE = DATA_BIT_WIDTH_INT + DATA_BIT_WIDTH_FRAC;

    localparam logic [DSIZE-1:0]            c_satMax    = {1'b0, {(DSIZE-1){1'b1}}};
    localparam logic [DSIZE-1:0]            c_satMin    = {1'b1, {(DSIZE-1){1'b0}}};
    localparam logic [REFRAC_BIT_WIDTH-1:0] c_refracOne = {{(REFRAC_BIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]                  c_typeRelu  = 2'd1;
`ifdef NURN_LEAK_EN
    localparam logic [1:0]                  c_typeLif   = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_LEAK = 3'd2,
        S_CMP  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Job registers
    logic [NURN_CNT_BIT_WIDTH-1:0] r_nurnId;
    logic [DSIZE-1:0]              r_th;
    logic [DSIZE-1:0]              r_rstPot;
    logic [REFRAC_BIT_WIDTH-1:0]   r_refracCnt;
    logic [REFRAC_BIT_WIDTH-1:0]   r_refracPeriod;
    logic [1:0]                    r_type;
    logic [DSIZE-1:0]              r_acc;

    // Result registers
    logic [NURN_CNT_BIT_WIDTH-1:0] r_resNurnId;
    logic [DSIZE-1:0]              r_resMembPot;
    logic [REFRAC_BIT_WIDTH-1:0]   r_resRefracCnt;
    logic                          r_outSpike;

    // Narrow a DSIZE+1 bit signed result back to DSIZE bits, clamping when
    // the two top bits disagree (i.e. the value left the representable range).
    function automatic logic [DSIZE-1:0] satTrunc(input logic [DSIZE:0] s);
        if (s[DSIZE] != s[DSIZE-1]) begin
            return s[DSIZE] ? c_satMin : c_satMax;
        end
        return s[DSIZE-1:0];
    endfunction

    logic [DSIZE:0]              w_addSum;
    logic                        w_refracZero;
    logic                        w_thReached;
    logic                        w_spike;
    logic [REFRAC_BIT_WIDTH-1:0] w_refracDec;
    logic                        w_transfer;

    assign w_addSum     = {r_acc[DSIZE-1], r_acc} + {syn_weight_i[DSIZE-1], syn_weight_i};
    assign w_refracZero = (r_refracCnt == '0);
    assign w_thReached  = ($signed(r_acc) >= $signed(r_th));
    assign w_spike      = w_refracZero & w_thReached;
    assign w_refracDec  = w_refracZero ? '0 : (r_refracCnt - c_refracOne);
    assign w_transfer   = syn_valid_i & syn_ready_o;

`ifdef NURN_LEAK_EN
    logic [LEAK_SHIFT_BIT_WIDTH-1:0] r_leakShift;
    logic signed [DSIZE-1:0]         w_accShifted;
    logic [DSIZE:0]                  w_leakDiff;

    assign w_accShifted = $signed(r_acc) >>> r_leakShift;
    assign w_leakDiff   = {r_acc[DSIZE-1], r_acc} - {w_accShifted[DSIZE-1], w_accShifted};
`else
    // leakShift_i has no effect when the leak is compiled out.
    logic w_unusedLeakShift;
    assign w_unusedLeakShift = ^leakShift_i;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = S_ACC;
                end
            end
            S_ACC: begin
                if (w_transfer && syn_last_i) begin
`ifdef NURN_LEAK_EN
                    w_nextState = S_LEAK;
`else
                    w_nextState = S_CMP;
`endif
                end
            end
            S_LEAK:  w_nextState = S_CMP;
            S_CMP:   w_nextState = S_OUT;
            S_OUT: begin
                if (result_ready_i) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: job capture, accumulation, leak, compare/result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_nurnId       <= '0;
            r_th           <= '0;
            r_rstPot       <= '0;
            r_refracCnt    <= '0;
            r_refracPeriod <= '0;
            r_type         <= '0;
            r_acc          <= '0;
`ifdef NURN_LEAK_EN
            r_leakShift    <= '0;
`endif
            r_resNurnId    <= '0;
            r_resMembPot   <= '0;
            r_resRefracCnt <= '0;
            r_outSpike     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_nurnId       <= nurnId_i;
                        r_th           <= th_i;
                        r_rstPot       <= rstPot_i;
                        r_refracCnt    <= refracCnt_i;
                        r_refracPeriod <= refracPeriod_i;
                        r_type         <= nurnType_i;
                        r_acc          <= membPot_i;
`ifdef NURN_LEAK_EN
                        r_leakShift    <= leakShift_i;
`endif
                    end
                end
                S_ACC: begin
                    // Refractory neurons ignore incoming spikes entirely.
                    if (w_transfer && syn_spike_i && w_refracZero) begin
                        r_acc <= satTrunc(w_addSum);
                    end
                end
                S_LEAK: begin
`ifdef NURN_LEAK_EN
                    if ((r_type == c_typeLif) && w_refracZero) begin
                        r_acc <= satTrunc(w_leakDiff);
                    end
`endif
                end
                S_CMP: begin
                    r_resNurnId <= r_nurnId;
                    r_outSpike  <= w_spike;
                    if (r_type == c_typeRelu) begin
                        // ReLU clamps negatives and never resets on a spike.
                        r_resMembPot   <= r_acc[DSIZE-1] ? '0 : r_acc;
                        r_resRefracCnt <= w_refracDec;
                    end else if (w_spike) begin
                        r_resMembPot   <= r_rstPot;
                        r_resRefracCnt <= r_refracPeriod;
                    end else begin
                        r_resMembPot   <= r_acc;
                        r_resRefracCnt <= w_refracDec;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign syn_ready_o        = (r_state == S_ACC);
    assign result_valid_o     = (r_state == S_OUT);
    assign busy_o             = (r_state != S_IDLE);
    assign result_nurnId_o    = r_resNurnId;
    assign result_membPot_o   = r_resMembPot;
    assign result_refracCnt_o = r_resRefracCnt;
    assign outSpike_o         = r_outSpike;

endmodule
`default_nettype wire

// File: tb/tb_nurn_update_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nurn_update_engine
//  Purpose  : Randomised and directed bench for nurn_update_engine. Expected
//             results come from an integer-arithmetic neuron model; a
//             negedge monitor compares every cycle result_valid_o is high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nurn_update_engine;

    localparam int DSIZE = 16;
    localparam int NW    = 8;
    localparam int RW    = 4;
    localparam int LW    = 4;
`ifdef NURN_LEAK_EN
    localparam bit c_leakEn  = 1'b1;
    localparam int c_expLat  = 2;
`else
    localparam bit c_leakEn  = 1'b0;
    localparam int c_expLat  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_i = 1'b0;
    logic [NW-1:0]    nurnId_i = '0;
    logic [DSIZE-1:0] membPot_i = '0, th_i = '0, rstPot_i = '0;
    logic [RW-1:0]    refracCnt_i = '0, refracPeriod_i = '0;
    logic [1:0]       nurnType_i = '0;
    logic [LW-1:0]    leakShift_i = '0;
    logic             syn_valid_i = 1'b0;
    logic             syn_ready_o;
    logic [DSIZE-1:0] syn_weight_i = '0;
    logic             syn_spike_i = 1'b0, syn_last_i = 1'b0;
    logic             result_valid_o;
    logic             result_ready_i = 1'b0;
    logic [NW-1:0]    result_nurnId_o;
    logic [DSIZE-1:0] result_membPot_o;
    logic [RW-1:0]    result_refracCnt_o;
    logic             outSpike_o, busy_o;

    always #5 clk = ~clk;

    nurn_update_engine #(
        .DATA_BIT_WIDTH_INT(8), .DATA_BIT_WIDTH_FRAC(8),
        .NURN_CNT_BIT_WIDTH(NW), .REFRAC_BIT_WIDTH(RW), .LEAK_SHIFT_BIT_WIDTH(LW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .nurnId_i(nurnId_i),
        .membPot_i(membPot_i), .th_i(th_i), .rstPot_i(rstPot_i),
        .refracCnt_i(refracCnt_i), .refracPeriod_i(refracPeriod_i),
        .nurnType_i(nurnType_i), .leakShift_i(leakShift_i),
        .syn_valid_i(syn_valid_i), .syn_ready_o(syn_ready_o),
        .syn_weight_i(syn_weight_i), .syn_spike_i(syn_spike_i), .syn_last_i(syn_last_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_nurnId_o(result_nurnId_o), .result_membPot_o(result_membPot_o),
        .result_refracCnt_o(result_refracCnt_o), .outSpike_o(outSpike_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic [NW-1:0]    id;
        logic [DSIZE-1:0] pot;
        logic [RW-1:0]    rc;
        logic             spk;
    } res_t;

    int   nCompared   = 0;
    int   nMismatched = 0;
    res_t expQ[$];
    int   qW[$];
    int   qS[$];
    res_t got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int s16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    function automatic int clamp(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Neuron behaviour computed from the rules with plain integers.
    function automatic res_t model(input int id, input int pot, input int th, input int rstp,
                                   input int rc, input int rp, input int typ, input int sh);
        res_t r;
        int   acc = s16(pot);
        int   d, q, potOut, rcOut;
        bit   spk;
        for (int i = 0; i < qW.size(); i++)
            if (qS[i] != 0 && rc == 0) acc = clamp(acc + s16(qW[i]));
        if (c_leakEn && typ == 2 && rc == 0) begin
            d = 1 << sh;
            q = acc / d;
            if (acc < 0 && (acc % d) != 0) q = q - 1;   // floor division
            acc = clamp(acc - q);
        end
        spk = (rc == 0) && (acc >= s16(th));
        if (typ == 1) begin
            potOut = (acc < 0) ? 0 : acc;
            rcOut  = (rc > 0) ? rc - 1 : 0;
        end else if (spk) begin
            potOut = rstp;
            rcOut  = rp;
        end else begin
            potOut = acc;
            rcOut  = (rc > 0) ? rc - 1 : 0;
        end
        r.id  = NW'(id);
        r.pot = DSIZE'(potOut);
        r.rc  = RW'(rcOut);
        r.spk = spk;
        return r;
    endfunction

    // Compare process: every cycle the result is presented it must equal the
    // head of the expected queue; the entry retires on the handshake.
    always @(negedge clk) begin
        if (!rst && result_valid_o) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL unexpected_result: actual valid=1 required no result pending at %0t", $time);
            end else begin
                check("res_id",    32'(result_nurnId_o),    32'(expQ[0].id));
                check("res_pot",   32'(result_membPot_o),   32'(expQ[0].pot));
                check("res_rc",    32'(result_refracCnt_o), 32'(expQ[0].rc));
                check("res_spike", 32'(outSpike_o),         32'(expQ[0].spk));
                check("res_busy",  32'(busy_o),             32'd1);
                if (result_ready_i) void'(expQ.pop_front());
            end
        end
    end

    task automatic startJob(input int id, input int pot, input int th, input int rstp,
                            input int rc, input int rp, input int typ, input int sh);
        nurnId_i       = NW'(id);
        membPot_i      = DSIZE'(pot);
        th_i           = DSIZE'(th);
        rstPot_i       = DSIZE'(rstp);
        refracCnt_i    = RW'(rc);
        refracPeriod_i = RW'(rp);
        nurnType_i     = 2'(typ);
        leakShift_i    = LW'(sh);
        start_i        = 1'b1;
        expQ.push_back(model(id, pot, th, rstp, rc, rp, typ, sh));
        @(posedge clk); #1;
        start_i = 1'b0;
        // Scramble job inputs: the DUT must use the values it latched.
        nurnId_i = NW'($urandom); membPot_i = DSIZE'($urandom); th_i = DSIZE'($urandom);
        rstPot_i = DSIZE'($urandom); refracCnt_i = RW'($urandom); refracPeriod_i = RW'($urandom);
        nurnType_i = 2'($urandom); leakShift_i = LW'($urandom);
        check("busy_after_start", 32'(busy_o), 32'd1);
    endtask

    task automatic sendBeats(input int nBeats);
        int guard;
        for (int i = 0; i < nBeats; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 1)); g++) begin
                syn_valid_i = 1'b0; syn_weight_i = DSIZE'($urandom);
                syn_spike_i = 1'b1; syn_last_i = 1'b1;
                @(posedge clk); #1;
            end
            syn_valid_i  = 1'b1;
            syn_weight_i = DSIZE'(qW[i]);
            syn_spike_i  = (qS[i] != 0);
            syn_last_i   = (i == qW.size() - 1);
            guard = 0;
            while (!syn_ready_o && guard < 20) begin
                @(posedge clk); #1; guard++;
            end
            if (guard >= 20) check("syn_ready_timeout", 32'(syn_ready_o), 32'd1);
            @(posedge clk); #1;
            syn_valid_i = 1'b0; syn_last_i = 1'b0; syn_spike_i = 1'b0;
        end
    endtask

    task automatic waitResult(input bit bp);
        int  n = 0, k = 0;
        bit  hs, done = 0;
        result_ready_i = 1'b0;
        while (!result_valid_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(c_expLat));
        while (!done && k < 50) begin
            if (bp && k < 5) begin
                result_ready_i = 1'b0;
                start_i        = 1'b1;
                if (k > 0) begin
                    check("bp_valid_held", 32'(result_valid_o), 32'd1);
                    check("bp_busy_held",  32'(busy_o),         32'd1);
                end
            end else begin
                start_i        = 1'b0;
                result_ready_i = bp ? 1'b1 : 1'($urandom);
            end
            hs = result_valid_o && result_ready_i;
            if (hs) got = '{result_nurnId_o, result_membPot_o, result_refracCnt_o, outSpike_o};
            @(posedge clk); #1;
            if (hs) done = 1;
            k++;
        end
        if (!done) check("handshake_timeout", 32'(done), 32'd1);
        result_ready_i = 1'b0;
        start_i        = 1'b0;
        check("idle_after_handshake", 32'(busy_o), 32'd0);
    endtask

    task automatic runJob(input int id, input int pot, input int th, input int rstp, input int rc,
                          input int rp, input int typ, input int sh, input bit bp);
        startJob(id, pot, th, rstp, rc, rp, typ, sh);
        sendBeats(qW.size());
        waitResult(bp);
    endtask

    task automatic checkGot(input string name, input int pot, input int rc, input int spk);
        check({name, "_pot"},   32'(got.pot), 32'(pot));
        check({name, "_rc"},    32'(got.rc),  32'(rc));
        check({name, "_spike"}, 32'(got.spk), 32'(spk));
    endtask

    initial begin
        #2 rst = 1'b1;
        #10;
        check("rst_busy",   32'(busy_o),             32'd0);
        check("rst_ready",  32'(syn_ready_o),        32'd0);
        check("rst_valid",  32'(result_valid_o),     32'd0);
        check("rst_pot",    32'(result_membPot_o),   32'd0);
        check("rst_spike",  32'(outSpike_o),         32'd0);
        @(negedge clk) rst = 1'b0;

        // I&F: three spiking 1.0 beats reach a 3.0 threshold and fire.
        qW = '{32'h0100, 32'h0100, 32'h0100}; qS = '{1, 1, 1};
        runJob(8'h11, 16'h0000, 16'h0300, 16'h0000, 0, 2, 0, 0, 0);
        checkGot("if_fire", 16'h0000, 2, 1);

        // ReLU positive saturation, no reset.
        qW = '{32'h0200}; qS = '{1};
        runJob(8'h12, 16'h7F00, 16'h7FFF, 16'h1234, 0, 3, 1, 0, 0);
        checkGot("relu_sat", 16'h7FFF, 0, 1);

        // ReLU negative clamps to zero.
        qW = '{32'hFE00}; qS = '{1};
        runJob(8'h13, 16'h0000, 16'h0100, 16'h1234, 0, 3, 1, 0, 0);
        checkGot("relu_neg", 16'h0000, 0, 0);

        // LIF leak (shift 2) on an empty synapse list.
        qW = '{32'h0000}; qS = '{0};
        runJob(8'h14, 16'h0400, 16'h0500, 16'h0000, 0, 1, 2, 2, 0);
        checkGot("lif_leak", c_leakEn ? 16'h0300 : 16'h0400, 0, 0);

        // Refractory neuron ignores spikes and counts down.
        qW = '{32'h0500}; qS = '{1};
        runJob(8'h15, 16'h0050, 16'h0100, 16'h0000, 2, 4, 0, 0, 0);
        checkGot("refrac", 16'h0050, 1, 0);

        // Negative saturation for I&F.
        qW = '{32'hFE00}; qS = '{1};
        runJob(8'h16, 16'h8100, 16'h0000, 16'h0000, 0, 1, 0, 0, 0);
        checkGot("neg_sat", 16'h8000, 0, 0);

        // Back-pressure: five cycles of ready low with start_i asserted.
        qW = '{32'h0000}; qS = '{0};
        runJob(8'h17, 16'h0200, 16'h0100, 16'h0000, 3, 5, 1, 0, 1);
        checkGot("bp", 16'h0200, 2, 0);

        // Reset in the middle of accumulation discards the job.
        qW = '{32'h0100, 32'h0100}; qS = '{1, 1};
        startJob(8'h18, 16'h0100, 16'h0100, 16'h0000, 0, 1, 0, 0);
        syn_valid_i = 1'b1; syn_weight_i = 16'h0100; syn_spike_i = 1'b1; syn_last_i = 1'b0;
        @(posedge clk); #1;
        syn_valid_i = 1'b0; syn_spike_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",  32'(busy_o),             32'd0);
        check("midrst_ready", 32'(syn_ready_o),        32'd0);
        check("midrst_valid", 32'(result_valid_o),     32'd0);
        check("midrst_id",    32'(result_nurnId_o),    32'd0);
        check("midrst_pot",   32'(result_membPot_o),   32'd0);
        check("midrst_rc",    32'(result_refracCnt_o), 32'd0);
        check("midrst_spike", 32'(outSpike_o),         32'd0);
        void'(expQ.pop_front());
        @(negedge clk) rst = 1'b0;
        // Start is driven straight away and must be taken on the first edge.
        qW = '{32'h0080}; qS = '{1};
        runJob(8'h19, 16'h0000, 16'h0100, 16'h0000, 0, 1, 0, 0, 0);
        checkGot("post_rst", 16'h0080, 0, 0);

        // Randomised jobs.
        for (int j = 0; j < 40; j++) begin
            int nb = $urandom_range(1, 5);
            int pot, th, rc;
            qW.delete(); qS.delete();
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) qW.push_back(int'($urandom & 32'hFFFF));
                else qW.push_back(int'(($urandom_range(0, 16'h0800) - 16'h0400) & 32'hFFFF));
                qS.push_back(int'($urandom_range(0, 3) != 0));
            end
            pot = ($urandom_range(0, 1) != 0) ? int'($urandom & 32'hFFFF)
                                               : int'(($urandom_range(0, 16'h1000) - 16'h0800) & 32'hFFFF);
            th  = int'(($urandom_range(0, 16'h1000) - 16'h0800) & 32'hFFFF);
            rc  = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
            runJob(int'($urandom & 32'hFF), pot, th, int'($urandom & 32'hFFFF), rc,
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), 0);
        end

        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
